// File: rtl/uart_rx_data_sampler_if.sv
// Bundles the serial line, sampler controls and sampler outputs.
// The slave modport is the sampler view; the master modport is the RX controller view.
interface uart_rx_data_sampler_if #(
  parameter int CNT_W = 6
);
  logic             RX_IN;
  logic [CNT_W-1:0] prescale;
  logic             sampler_enable;
  logic             sampled_data;
  logic             sampled_data_valid;
  logic [CNT_W-1:0] edge_cnt;
  logic [3:0]       bit_cnt;

  modport master (
    output RX_IN, prescale, sampler_enable,
    input  sampled_data, sampled_data_valid, edge_cnt, bit_cnt
  );

  modport slave (
    input  RX_IN, prescale, sampler_enable,
    output sampled_data, sampled_data_valid, edge_cnt, bit_cnt
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling front end: counts edges within each bit and takes three samples around
// the bit centre, emitting one majority-voted bit per bit period with a one-cycle strobe.
module uart_rx_data_sampler #(
  parameter int FRAME_BITS = 11,
  parameter int CNT_W      = 6
) (
  input logic                   clk_based_on_prescale,
  input logic                   rst,
  uart_rx_data_sampler_if.slave bus
);

  logic [CNT_W-1:0] r_edge_cnt;
  logic [3:0]       r_bit_cnt;
  logic             r_s0;
  logic             r_s1;
  logic             r_data;
  logic             r_valid;

  logic [CNT_W-1:0] w_p;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_mid;
  logic             w_wrap;
  logic [CNT_W-1:0] w_edge_cnt_nxt;
  logic [3:0]       w_bit_cnt_nxt;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Effective oversampling ratio: unsupported prescale values fall back to 8
  always_comb begin
    case (bus.prescale)
      CNT_W'(16): w_p = CNT_W'(16);
      CNT_W'(32): w_p = CNT_W'(32);
      default:    w_p = CNT_W'(8);
    endcase
  end

  assign w_last = w_p - CNT_W'(1);
  assign w_mid  = w_p >> 1;
  // >= rather than == so a stale count above a newly smaller ratio still wraps
  assign w_wrap = (r_edge_cnt >= w_last);

  // Next edge/bit counter values while enabled
  always_comb begin
    w_edge_cnt_nxt = r_edge_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    if (w_wrap) begin
      w_edge_cnt_nxt = '0;
      if (r_bit_cnt >= 4'(FRAME_BITS - 1)) begin
        w_bit_cnt_nxt = 4'd0;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
      end
    end else begin
      w_edge_cnt_nxt = r_edge_cnt + CNT_W'(1);
    end
  end

  // Counters, three-point sampling and the voted output; disable clears all but the last bit
  always_ff @(posedge clk_based_on_prescale) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_data     <= 1'b1;
      r_valid    <= 1'b0;
    end else if (!bus.sampler_enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_data     <= r_data;
      r_valid    <= 1'b0;
    end else begin
      r_edge_cnt <= w_edge_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_valid    <= 1'b0;
      if (r_edge_cnt == (w_mid - CNT_W'(1))) begin
        r_s0 <= bus.RX_IN;
      end
      if (r_edge_cnt == w_mid) begin
        r_s1 <= bus.RX_IN;
      end
      if (r_edge_cnt == (w_mid + CNT_W'(1))) begin
        r_data  <= majority3(r_s0, r_s1, bus.RX_IN);
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.sampled_data       = r_data;
  assign bus.sampled_data_valid = r_valid;
  assign bus.edge_cnt           = r_edge_cnt;
  assign bus.bit_cnt            = r_bit_cnt;

endmodule
